prescaler_ce: RTL



---
 rtl/prescaler_pkg.sv | 22 ++
 rtl/prescaler_ce_tap.sv | 44 ++++
 rtl/prescaler_ce.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/prescaler_pkg.sv
// Shared constants and helpers for the prescaler_ce clock-enable generator.
// Tap positions are packed TAP_POS_W-bit fields, field i belongs to tap i.
package prescaler_pkg;

    localparam int TAP_POS_W    = 5;
    localparam int MAX_TAPS     = 16;
    localparam int DEF_NUM_TAPS = 4;

    localparam logic [DEF_NUM_TAPS*TAP_POS_W-1:0] DEF_TAP_POS =
        {5'd20, 5'd17, 5'd10, 5'd6};

    // Tap indices into the default layout used by board-level consumers.
    localparam int LED_SLOW_TAP = 3;
    localparam int DEBOUNCE_TAP = 2;

    typedef logic [MAX_TAPS*TAP_POS_W-1:0] tap_pos_vec_t;

    function automatic int tap_pos(input tap_pos_vec_t v, input int i);
        return int'(v[i*TAP_POS_W +: TAP_POS_W]);
    endfunction

endpackage

// File: rtl/prescaler_ce_tap.sv
// Rising-edge tick generator for one counter bit: the tick is registered
// so it lines up with the first ct value that shows the bit set.
module prescaler_tap #(
    parameter int CT_WIDTH = 21,
    parameter int POS      = 0
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                en_i,
    input  logic                clr_i,
    input  logic [CT_WIDTH-1:0] ct_i,
    output logic                level_o,
    output logic                tick_o
);

    localparam logic [CT_WIDTH-1:0] LOW_MASK =
        CT_WIDTH'((64'd1 << POS) - 64'd1);

    logic low_ones;
    logic tick_d;
    logic tick_q;

    assign low_ones = ((ct_i & LOW_MASK) == LOW_MASK);

    // Bit is about to flip 0->1 on this enabled increment.
    always_comb begin
        tick_d = 1'b0;
        if (!clr_i && en_i) begin
            tick_d = low_ones & ~ct_i[POS];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign level_o = ct_i[POS];
    assign tick_o  = tick_q;

endmodule

// File: rtl/prescaler_ce.sv
// Free-running prescaler producing single-cycle clock enables on clk.
// Optional ct snapshot port is built when PRESCALER_SNAPSHOT_EN is defined.
module prescaler_ce
    import prescaler_pkg::*;
#(
    parameter int CT_WIDTH = 21,
    parameter int NUM_TAPS = DEF_NUM_TAPS,
    parameter logic [NUM_TAPS*TAP_POS_W-1:0] TAP_POS = DEF_TAP_POS,
    parameter int SUB_TAP  = DEBOUNCE_TAP,
    parameter int SUB_W    = 4,
    parameter int DIV_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                clr,
    output logic [NUM_TAPS-1:0] tap_level,
    output logic [NUM_TAPS-1:0] tap_tick,
    output logic                slow_phase0,
    output logic                slow_tick,
    input  logic                div_load,
    input  logic [DIV_W-1:0]    div_val,
    output logic                div_tick
`ifdef PRESCALER_SNAPSHOT_EN
    ,
    input  logic                snap,
    output logic [CT_WIDTH-1:0] ct_snap
`endif
);

    localparam tap_pos_vec_t TAP_VEC = tap_pos_vec_t'(TAP_POS);

    logic [CT_WIDTH-1:0] ct_q;
    logic [CT_WIDTH-1:0] ct_d;

    always_comb begin
        ct_d = ct_q;
        if (clr) begin
            ct_d = '0;
        end else if (en) begin
            ct_d = ct_q + CT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ct_q <= '0;
        end else begin
            ct_q <= ct_d;
        end
    end

    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_tap
        prescaler_tap #(
            .CT_WIDTH (CT_WIDTH),
            .POS      (tap_pos(TAP_VEC, g))
        ) u_tap (
            .clk_i    (clk),
            .reset_i  (reset),
            .en_i     (en),
            .clr_i    (clr),
            .ct_i     (ct_q),
            .level_o  (tap_level[g]),
            .tick_o   (tap_tick[g])
        );
    end

    logic [SUB_W-1:0] sub_q;
    logic [SUB_W-1:0] sub_d;
    logic             sub_inc;
    logic             phase0_q;
    logic             phase0_d;
    logic             slow_tick_q;
    logic             slow_tick_d;

    // Counts visible ticks, so a tick seen as en drops is not lost.
    assign sub_inc = tap_tick[SUB_TAP];

    always_comb begin
        sub_d       = sub_q;
        slow_tick_d = 1'b0;
        if (clr) begin
            sub_d = '0;
        end else if (sub_inc) begin
            sub_d       = sub_q + SUB_W'(1);
            slow_tick_d = (sub_q == '1);
        end
        phase0_d = (sub_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sub_q       <= '0;
            phase0_q    <= 1'b1;
            slow_tick_q <= 1'b0;
        end else begin
            sub_q       <= sub_d;
            phase0_q    <= phase0_d;
            slow_tick_q <= slow_tick_d;
        end
    end

    assign slow_phase0 = phase0_q;
    assign slow_tick   = slow_tick_q;

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic [DIV_W-1:0] div_rel_q;
    logic [DIV_W-1:0] div_rel_d;
    logic             div_armed_q;
    logic             div_armed_d;
    logic             div_tick_q;
    logic             div_tick_d;

    // A load overrides clr for the count and is not gated by en.
    always_comb begin
        div_cnt_d   = div_cnt_q;
        div_rel_d   = div_rel_q;
        div_armed_d = div_armed_q;
        div_tick_d  = 1'b0;
        if (div_load) begin
            div_rel_d   = div_val;
            div_cnt_d   = div_val;
            div_armed_d = 1'b1;
        end else if (clr) begin
            div_cnt_d = div_rel_q;
        end else if (en && div_armed_q) begin
            if (div_cnt_q == '0) begin
                div_tick_d = 1'b1;
                div_cnt_d  = div_rel_q;
            end else begin
                div_cnt_d = div_cnt_q - DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q   <= '0;
            div_rel_q   <= '0;
            div_armed_q <= 1'b0;
            div_tick_q  <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            div_rel_q   <= div_rel_d;
            div_armed_q <= div_armed_d;
            div_tick_q  <= div_tick_d;
        end
    end

    assign div_tick = div_tick_q;

`ifdef PRESCALER_SNAPSHOT_EN
    logic [CT_WIDTH-1:0] ct_snap_q;
    logic [CT_WIDTH-1:0] ct_snap_d;

    always_comb begin
        ct_snap_d = ct_snap_q;
        if (snap) begin
            ct_snap_d = ct_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ct_snap_q <= '0;
        end else begin
            ct_snap_q <= ct_snap_d;
        end
    end

    assign ct_snap = ct_snap_q;
`endif

endmodule
